// File: rtl/orb_frame_serializer_if.sv
// Bus between the orbit frame serializer and its surroundings: the bit-rate
// strobe, the two packer RAM read ports and the serial telemetry outputs.
// The master modport is the serializer side, the slave modport is the
// environment (packer RAMs, bit clock and telemetry sink).
interface orb_frame_serializer_if #(
  parameter int ADDR_W = 11
);
  logic              bitEn;
  logic [11:0]       rdData1;
  logic [11:0]       rdData2;
  logic [ADDR_W-1:0] rdAddr;
  logic              rdEn;
  logic              sDat;
  logic              frameSync;
  logic              SW;
  logic              busy;

  modport master (
    input  bitEn, rdData1, rdData2,
    output rdAddr, rdEn, sDat, frameSync, SW, busy
  );

  modport slave (
    output bitEn, rdData1, rdData2,
    input  rdAddr, rdEn, sDat, frameSync, SW, busy
  );
endinterface

// File: rtl/orb_frame_serializer.sv
// Orbit frame serializer: reads packed 12-bit orbit words from the two packer
// RAMs (even addresses from RAM1, odd from RAM2) and emits a continuous NRZ
// frame, MSB first, one bit per bitEn: a 12-bit sync word followed by
// FRAME_WORDS data words. SW toggles at every frame boundary after the first.
// Optional feature macro ORB_PARITY_EN: when defined, every data word is
// followed by one odd-parity bit (13 strobes per data word); the sync word
// stays 12 bits.
module orb_frame_serializer #(
  parameter int          FRAME_WORDS = 1024,
  parameter int          ADDR_W      = 11,
  parameter logic [11:0] SYNC_WORD   = 12'hE2D
) (
  input logic                    clk,
  input logic                    rst,
  orb_frame_serializer_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [3:0] SYNC_BITS = 4'd12;
`ifdef ORB_PARITY_EN
  localparam logic [3:0] DATA_BITS = 4'd13;
`else
  localparam logic [3:0] DATA_BITS = 4'd12;
`endif

  localparam logic [ADDR_W-1:0] LAST_WORD      = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] FIRST_PREFETCH = ADDR_W'(1);

  logic [1:0]        state_q,     state_d;
  logic [11:0]       shift_q,     shift_d;
  logic [3:0]        bitCnt_q,    bitCnt_d;
  logic [ADDR_W-1:0] wordCnt_q,   wordCnt_d;
  logic [11:0]       hold_q,      hold_d;
  logic              capPend_q,   capPend_d;
  logic              sDat_q,      sDat_d;
  logic [ADDR_W-1:0] rdAddr_q,    rdAddr_d;
  logic              rdEn_q,      rdEn_d;
  logic              frameSync_q, frameSync_d;
  logic              sw_q,        sw_d;
  logic              busy_q,      busy_d;
`ifdef ORB_PARITY_EN
  logic              parity_q,    parity_d;
`endif
  logic [ADDR_W-1:0] nextWord;

  // Next-state logic: word loads, bit shifting, prefetch issue and capture
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitCnt_d    = bitCnt_q;
    wordCnt_d   = wordCnt_q;
    sDat_d      = sDat_q;
    rdAddr_d    = rdAddr_q;
    rdEn_d      = 1'b0;
    frameSync_d = 1'b0;
    sw_d        = sw_q;
    busy_d      = busy_q;
    capPend_d   = rdEn_q;
    hold_d      = hold_q;
`ifdef ORB_PARITY_EN
    parity_d    = parity_q;
`endif
    nextWord    = wordCnt_q + ADDR_W'(1);

    // RAM data is valid one clock after the read strobe; the shared address
    // is still stable then because loads are at least 4 clocks apart.
    if (capPend_q) begin
      hold_d = rdAddr_q[0] ? bus.rdData2 : bus.rdData1;
    end

    if (bus.bitEn) begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_SYNC;
          sDat_d      = SYNC_WORD[11];
          shift_d     = {SYNC_WORD[10:0], 1'b0};
          bitCnt_d    = 4'd1;
          wordCnt_d   = '0;
          frameSync_d = 1'b1;
          busy_d      = 1'b1;
          rdEn_d      = 1'b1;
          rdAddr_d    = '0;
        end

        ST_SYNC: begin
          if (bitCnt_q == SYNC_BITS) begin
            state_d   = ST_DATA;
            sDat_d    = hold_q[11];
            shift_d   = {hold_q[10:0], 1'b0};
            bitCnt_d  = 4'd1;
            wordCnt_d = '0;
            rdEn_d    = 1'b1;
            rdAddr_d  = FIRST_PREFETCH;
`ifdef ORB_PARITY_EN
            parity_d  = ~^hold_q;
`endif
          end else begin
            sDat_d   = shift_q[11];
            shift_d  = {shift_q[10:0], 1'b0};
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end

        ST_DATA: begin
          if (bitCnt_q == DATA_BITS) begin
            bitCnt_d = 4'd1;
            rdEn_d   = 1'b1;
            if (wordCnt_q == LAST_WORD) begin
              // Frame boundary: restart with the sync word and flip the bank
              state_d     = ST_SYNC;
              sDat_d      = SYNC_WORD[11];
              shift_d     = {SYNC_WORD[10:0], 1'b0};
              wordCnt_d   = '0;
              frameSync_d = 1'b1;
              sw_d        = ~sw_q;
              rdAddr_d    = '0;
            end else begin
              sDat_d    = hold_q[11];
              shift_d   = {hold_q[10:0], 1'b0};
              wordCnt_d = nextWord;
              rdAddr_d  = (nextWord == LAST_WORD) ? '0 : nextWord + ADDR_W'(1);
`ifdef ORB_PARITY_EN
              parity_d  = ~^hold_q;
`endif
            end
`ifdef ORB_PARITY_EN
          end else if (bitCnt_q == 4'd12) begin
            sDat_d   = parity_q;
            bitCnt_d = bitCnt_q + 4'd1;
`endif
          end else begin
            sDat_d   = shift_q[11];
            shift_d  = {shift_q[10:0], 1'b0};
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bitCnt_q    <= '0;
      wordCnt_q   <= '0;
      hold_q      <= '0;
      capPend_q   <= 1'b0;
      sDat_q      <= 1'b0;
      rdAddr_q    <= '0;
      rdEn_q      <= 1'b0;
      frameSync_q <= 1'b0;
      sw_q        <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ORB_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitCnt_q    <= bitCnt_d;
      wordCnt_q   <= wordCnt_d;
      hold_q      <= hold_d;
      capPend_q   <= capPend_d;
      sDat_q      <= sDat_d;
      rdAddr_q    <= rdAddr_d;
      rdEn_q      <= rdEn_d;
      frameSync_q <= frameSync_d;
      sw_q        <= sw_d;
      busy_q      <= busy_d;
`ifdef ORB_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign bus.sDat      = sDat_q;
  assign bus.rdAddr    = rdAddr_q;
  assign bus.rdEn      = rdEn_q;
  assign bus.frameSync = frameSync_q;
  assign bus.SW        = sw_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_orb_frame_serializer.sv
// Scoreboard bench for orb_frame_serializer. The driver issues bitEn strobes
// and queues the expected bit, frame marker, SW level and read request from a
// frame-position model; a monitor pops and compares on every strobe clock and
// checks that outputs hold in between. Honours ORB_PARITY_EN like the design.
module tb_orb_frame_serializer;

  localparam int FW = 4;
  localparam int AW = 11;
`ifdef ORB_PARITY_EN
  localparam int WL = 13;
`else
  localparam int WL = 12;
`endif
  localparam int          FRAME_LEN = 12 + WL * FW;
  localparam logic [11:0] SYNC      = 12'hE2D;

  typedef struct {
    logic sDat;
    logic fs;
    logic sw;
    logic rdEn;
    int   addr;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  orb_frame_serializer_if #(.ADDR_W(AW)) bus ();

  orb_frame_serializer #(
    .FRAME_WORDS(FW),
    .ADDR_W     (AW),
    .SYNC_WORD  (SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [11:0] ram1 [2048];
  logic [11:0] ram2 [2048];
  expect_t     expQ [$];
  int          bitIdx = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        lastSdat = 1'b0;
  logic        monEn;
  expect_t     monExp;

  // Synchronous packer RAM models: data appears one clock after rdEn
  always @(posedge clk) begin
    if (!rst) begin
      bus.rdData1 <= 12'h000;
      bus.rdData2 <= 12'h000;
    end else if (bus.rdEn) begin
      bus.rdData1 <= ram1[bus.rdAddr];
      bus.rdData2 <= ram2[bus.rdAddr];
    end
  end

  // Reference model: what the line carries at a given bit index since frame start
  function automatic expect_t modelBit(int idx);
    expect_t     e;
    int          pos;
    int          d;
    int          k;
    int          b;
    logic [11:0] w;
    logic [11:0] s;
    s      = SYNC;
    pos    = idx % FRAME_LEN;
    e.sw   = ((idx / FRAME_LEN) % 2) == 1;
    e.fs   = (pos == 0);
    e.rdEn = 1'b0;
    e.addr = 0;
    if (pos < 12) begin
      e.sDat = s[11 - pos];
      if (pos == 0) e.rdEn = 1'b1;
    end else begin
      d = pos - 12;
      k = d / WL;
      b = d % WL;
      w = (k % 2 == 0) ? ram1[k] : ram2[k];
      if (b < 12) e.sDat = w[11 - b];
      else        e.sDat = ($countones(w) % 2) == 0;
      if (b == 0) begin
        e.rdEn = 1'b1;
        e.addr = (k + 1) % FW;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(string name, int actual, int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (bit %0d, t=%0t)",
               name, actual, expected, bitIdx, $time);
    end
  endtask

  task automatic applyStimulus(int spacing);
    expQ.push_back(modelBit(bitIdx));
    bitIdx++;
    bus.bitEn = 1'b1;
    @(negedge clk);
    bus.bitEn = 1'b0;
    repeat (spacing - 1) @(negedge clk);
  endtask

  // Monitor: compare on strobe clocks, check hold behaviour on the others
  always @(posedge clk) begin
    monEn = bus.bitEn;
    #1;
    if (!rst) begin
      lastSdat = 1'b0;
    end else if (monEn) begin
      if (expQ.size() == 0) begin
        checkOutput("scoreboardEmpty", 1, 0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("sDat", bus.sDat, monExp.sDat);
        checkOutput("frameSync", bus.frameSync, monExp.fs);
        checkOutput("SW", bus.SW, monExp.sw);
        checkOutput("busy", bus.busy, 1);
        checkOutput("rdEn", bus.rdEn, monExp.rdEn);
        if (monExp.rdEn) checkOutput("rdAddr", int'(bus.rdAddr), monExp.addr);
        lastSdat = monExp.sDat;
      end
    end else begin
      checkOutput("sDatHold", bus.sDat, lastSdat);
      checkOutput("frameSyncPulse", bus.frameSync, 0);
      checkOutput("rdEnPulse", bus.rdEn, 0);
    end
  end

  initial begin
    bus.bitEn = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      ram1[i] = 12'($urandom);
      ram2[i] = 12'($urandom);
    end
    ram1[0] = 12'h123;
    ram2[1] = 12'h456;
    ram1[2] = 12'h789;
    ram2[3] = 12'hABC;

    repeat (3) @(negedge clk);
    checkOutput("resetSDat", bus.sDat, 0);
    checkOutput("resetRdAddr", int'(bus.rdAddr), 0);
    checkOutput("resetRdEn", bus.rdEn, 0);
    checkOutput("resetFrameSync", bus.frameSync, 0);
    checkOutput("resetSW", bus.SW, 0);
    checkOutput("resetBusy", bus.busy, 0);

    // First strobe coincides with reset release; two frames at spacing 8
    rst = 1'b1;
    for (int i = 0; i < 2 * FRAME_LEN + 3; i++) applyStimulus(8);

    // Run into data word 2, then reset asynchronously mid-frame
    while ((bitIdx % FRAME_LEN) != 12 + 2 * WL + 5) applyStimulus(8);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midResetSDat", bus.sDat, 0);
    checkOutput("midResetSW", bus.SW, 0);
    checkOutput("midResetBusy", bus.busy, 0);
    checkOutput("midResetFrameSync", bus.frameSync, 0);
    checkOutput("midResetRdAddr", int'(bus.rdAddr), 0);
    expQ.delete();
    bitIdx = 0;

    // New RAM contents while held in reset, including a parity-0 word
    for (int i = 0; i < FW; i++) begin
      ram1[i] = 12'($urandom);
      ram2[i] = 12'($urandom);
    end
    ram1[0] = 12'h123;
    ram2[1] = 12'h456;
    ram1[2] = 12'h007;
    @(negedge clk);
    @(negedge clk);

    // Restart at the tightest legal spacing, then random spacing
    rst = 1'b1;
    for (int i = 0; i < 2 * FRAME_LEN + 2; i++) applyStimulus(4);
    for (int i = 0; i < FRAME_LEN; i++) applyStimulus(int'($urandom_range(9, 4)));
    repeat (10) @(negedge clk);

    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
